junction_ctrl: RTL
==================

JUNCTION_CTRL -- requirements
Module: junction_ctrl

Interface
REQ-001 Parameter T_RDYLW, 2, red+amber duration in cycles (>=1).
REQ-002 Parameter T_GMIN, 4, minimum green in cycles (>=1).
REQ-003 Parameter T_GMAX, 10, maximum green under conflicting demand (>=T_GMIN).
REQ-004 Parameter T_YLW, 3, amber duration in cycles (>=1).
REQ-005 Parameter T_ALLRED, 2, all-red clearance in cycles (>=1).
REQ-006 Parameter T_WALK, 6, pedestrian walk duration in cycles (>=1).
REQ-007 clk  in  1  single clock, all state changes on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 enable  in  1  junction run request.
REQ-010 req_a / req_b  in  1 each  vehicle detector level for road A / road B.
REQ-011 ped_req  in  1  pedestrian push-button, any pulse width >=1 cycle.
REQ-012 lamp_a / lamp_b  out  3 each  {red, amber, green} for road A / road B.
REQ-013 walk  out  1  pedestrian walk lamp; ped_wait  out  1  pedestrian demand latched.
REQ-014 state_out  out  9  one-hot state: bit0 OFF, 1 ALL_RED, 2 A_RDYLW, 3 A_GREEN, 4 A_YELLOW, 5 B_RDYLW, 6 B_GREEN, 7 B_YELLOW, 8 WALK.

Function
REQ-015 Outputs SHALL be Moore-decoded from the registered state; exactly one state_out bit high at all times.
REQ-016 Lamps: OFF a=b=000; ALL_RED/WALK a=b=100; A_RDYLW a=110; A_GREEN a=001; A_YELLOW a=010 (b=100 in all A states); B states symmetric with a=100; walk=1 only in WALK.
REQ-017 A timed state of duration T SHALL occupy exactly T cycles; 8-bit elapsed counter clears on every state entry and saturates at 255.
REQ-018 Demand latches pend_a, pend_b, pend_p SHALL set on any cycle their input is high; pend_a cleared on entry to A_GREEN and not set while in A_RDYLW/A_GREEN; B likewise; pend_p cleared on WALK entry and not set during WALK.
REQ-019 ped_wait SHALL equal pend_p.
REQ-020 OFF: enable=1 -> ALL_RED next cycle; enable=0 -> remain OFF.
REQ-021 ALL_RED: after T_ALLRED cycles, enable=0 -> OFF; else, if any pend set, go to first pending of A->B->PED order starting after last_served (A -> A_RDYLW, B -> B_RDYLW, PED -> WALK); if none pending, rest in ALL_RED and re-evaluate each cycle.
REQ-022 last_served SHALL update on entry to A_RDYLW, B_RDYLW or WALK.
REQ-023 X_RDYLW -> X_GREEN after T_RDYLW cycles regardless of enable.
REQ-024 X_GREEN exits to X_YELLOW when elapsed>=T_GMIN and (enable=0, or conflicting demand exists and (own req=0 or elapsed>=T_GMAX)); conflicting demand = other road pend or pend_p.
REQ-025 X_GREEN with enable=1 and no conflicting demand SHALL rest indefinitely.
REQ-026 X_YELLOW -> ALL_RED after T_YLW cycles; WALK -> ALL_RED after T_WALK cycles; neither shortened by enable=0.
REQ-027 No state SHALL ever show green or walk concurrently with green/amber on the other road (all-red always separates conflicting phases).
REQ-028 Simultaneous requests in one cycle SHALL all latch; arbitration order per REQ-021 only.

Reset
REQ-029 rst_n low SHALL immediately force state OFF, lamps 000, walk 0, counter 0, all pend 0, last_served=PED.
REQ-030 Reset mid-operation SHALL abandon the current phase with no clearance; first post-reset transition per REQ-020.

Verification
REQ-031 Reset, enable=1, no requests -> OFF 1 cycle, ALL_RED rests with a=b=100, walk=0.
REQ-032 From resting ALL_RED, 1-cycle req_a pulse -> A_RDYLW 2 cycles (a=110), A_GREEN rests (a=001), pend_a=0.
REQ-033 In A_GREEN, req_a held 1, req_b pulsed at entry cycle -> green exactly 10 cycles, A_YELLOW 3, ALL_RED 2, B_RDYLW 2, B_GREEN.
REQ-034 After reset, req_a, req_b, ped_req pulsed same cycle during ALL_RED -> service order A, B, WALK (walk=1 for 6 cycles), then rest ALL_RED.
REQ-035 enable dropped during A_YELLOW -> yellow completes 3 cycles, ALL_RED 2, OFF; enable=1 -> ALL_RED 2 cycles, then pending demand served.
REQ-036 rst_n low during B_GREEN -> same-cycle lamps 000, state_out=9'b000000001, ped_wait=0.

Source files
------------

// File: rtl/junction_ctrl_if.sv
// Signal bundle between the junction controller and its surroundings:
// run request, vehicle detectors, pedestrian button in; lamps and status out.
interface junction_ctrl_if;
    logic       enable;
    logic       req_a;
    logic       req_b;
    logic       ped_req;
    logic [2:0] lamp_a;
    logic [2:0] lamp_b;
    logic       walk;
    logic       ped_wait;
    logic [8:0] state_out;

    // Master drives the requests and observes the lamps.
    modport master (
        output enable,
        output req_a,
        output req_b,
        output ped_req,
        input  lamp_a,
        input  lamp_b,
        input  walk,
        input  ped_wait,
        input  state_out
    );

    // Slave is the controller itself.
    modport slave (
        input  enable,
        input  req_a,
        input  req_b,
        input  ped_req,
        output lamp_a,
        output lamp_b,
        output walk,
        output ped_wait,
        output state_out
    );
endinterface

// File: rtl/junction_ctrl.sv
// Two-road traffic junction with a pedestrian phase. Every conflicting phase is
// separated by an all-red clearance; service rotates A -> B -> PED after the
// phase served last. Lamps are {red, amber, green}.
module junction_ctrl #(
    parameter int unsigned T_RDYLW  = 2,
    parameter int unsigned T_GMIN   = 4,
    parameter int unsigned T_GMAX   = 10,
    parameter int unsigned T_YLW    = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_WALK   = 6
) (
    input logic             clk,
    input logic             rst_n,
    junction_ctrl_if.slave  bus
);

    // State encoding.
    localparam logic [3:0] StOff     = 4'd0;
    localparam logic [3:0] StAllRed  = 4'd1;
    localparam logic [3:0] StARdylw  = 4'd2;
    localparam logic [3:0] StAGreen  = 4'd3;
    localparam logic [3:0] StAYellow = 4'd4;
    localparam logic [3:0] StBRdylw  = 4'd5;
    localparam logic [3:0] StBGreen  = 4'd6;
    localparam logic [3:0] StBYellow = 4'd7;
    localparam logic [3:0] StWalk    = 4'd8;

    // Service identifiers for the rotating arbiter.
    localparam logic [1:0] SrvA   = 2'd0;
    localparam logic [1:0] SrvB   = 2'd1;
    localparam logic [1:0] SrvPed = 2'd2;

    localparam logic [2:0] LampOff    = 3'b000;
    localparam logic [2:0] LampRed    = 3'b100;
    localparam logic [2:0] LampRedAmb = 3'b110;
    localparam logic [2:0] LampAmber  = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b001;

    localparam logic [7:0] CntMax = 8'hff;

    // The counter reads 0 in the first cycle of a state, so a state of
    // duration T is complete when the counter reaches T-1.
    localparam logic [7:0] LastRdylw  = 8'(T_RDYLW - 1);
    localparam logic [7:0] LastGmin   = 8'(T_GMIN - 1);
    localparam logic [7:0] LastGmax   = 8'(T_GMAX - 1);
    localparam logic [7:0] LastYlw    = 8'(T_YLW - 1);
    localparam logic [7:0] LastAllRed = 8'(T_ALLRED - 1);
    localparam logic [7:0] LastWalk   = 8'(T_WALK - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_a_q, pend_a_d;
    logic       pend_b_q, pend_b_d;
    logic       pend_p_q, pend_p_d;
    logic [1:0] last_q, last_d;

    logic       pick_valid;
    logic [1:0] pick_srv;
    logic [3:0] pick_state;
    logic       green_a_done;
    logic       green_b_done;
    logic       state_change;

    logic [2:0] lamp_a;
    logic [2:0] lamp_b;
    logic       walk;
    logic [8:0] state_out;

    // Rotating arbiter: first pending service after the one served last.
    always_comb begin
        pick_valid = 1'b0;
        pick_srv   = SrvA;
        case (last_q)
            SrvA: begin
                if (pend_b_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvB;
                end else if (pend_p_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvPed;
                end else if (pend_a_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvA;
                end
            end
            SrvB: begin
                if (pend_p_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvPed;
                end else if (pend_a_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvA;
                end else if (pend_b_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvB;
                end
            end
            default: begin
                if (pend_a_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvA;
                end else if (pend_b_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvB;
                end else if (pend_p_q) begin
                    pick_valid = 1'b1;
                    pick_srv   = SrvPed;
                end
            end
        endcase
    end

    // Phase that opens the chosen service.
    always_comb begin
        case (pick_srv)
            SrvA:    pick_state = StARdylw;
            SrvB:    pick_state = StBRdylw;
            default: pick_state = StWalk;
        endcase
    end

    // Green ends after the minimum once enable drops, or once there is
    // conflicting demand and either own traffic has gone or the maximum is hit.
    always_comb begin
        green_a_done = (cnt_q >= LastGmin) &&
                       (!bus.enable ||
                        ((pend_b_q || pend_p_q) && (!bus.req_a || (cnt_q >= LastGmax))));
        green_b_done = (cnt_q >= LastGmin) &&
                       (!bus.enable ||
                        ((pend_a_q || pend_p_q) && (!bus.req_b || (cnt_q >= LastGmax))));
    end

    // Next-state and last-served selection.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            StOff: begin
                if (bus.enable) begin
                    state_d = StAllRed;
                end
            end
            StAllRed: begin
                // Once clearance is over, keep re-evaluating every cycle.
                if (cnt_q >= LastAllRed) begin
                    if (!bus.enable) begin
                        state_d = StOff;
                    end else if (pick_valid) begin
                        state_d = pick_state;
                        last_d  = pick_srv;
                    end
                end
            end
            StARdylw:  if (cnt_q >= LastRdylw) state_d = StAGreen;
            StAGreen:  if (green_a_done)       state_d = StAYellow;
            StAYellow: if (cnt_q >= LastYlw)   state_d = StAllRed;
            StBRdylw:  if (cnt_q >= LastRdylw) state_d = StBGreen;
            StBGreen:  if (green_b_done)       state_d = StBYellow;
            StBYellow: if (cnt_q >= LastYlw)   state_d = StAllRed;
            StWalk:    if (cnt_q >= LastWalk)  state_d = StAllRed;
            default:   state_d = StOff;
        endcase
    end

    assign state_change = (state_d != state_q);

    // Elapsed counter: cleared on every state entry, saturating while resting.
    always_comb begin
        if (state_change) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Demand latches: ignore own request while being served, clear on service start.
    always_comb begin
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;
        pend_p_d = pend_p_q;
        if (bus.req_a && (state_q != StARdylw) && (state_q != StAGreen)) begin
            pend_a_d = 1'b1;
        end
        if (bus.req_b && (state_q != StBRdylw) && (state_q != StBGreen)) begin
            pend_b_d = 1'b1;
        end
        if (bus.ped_req && (state_q != StWalk)) begin
            pend_p_d = 1'b1;
        end
        if ((state_d == StAGreen) && (state_q != StAGreen)) begin
            pend_a_d = 1'b0;
        end
        if ((state_d == StBGreen) && (state_q != StBGreen)) begin
            pend_b_d = 1'b0;
        end
        if ((state_d == StWalk) && (state_q != StWalk)) begin
            pend_p_d = 1'b0;
        end
    end

    // State registers; reset abandons any phase without clearance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StOff;
            cnt_q    <= 8'd0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            pend_p_q <= 1'b0;
            last_q   <= SrvPed;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            pend_p_q <= pend_p_d;
            last_q   <= last_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        lamp_a    = LampRed;
        lamp_b    = LampRed;
        walk      = 1'b0;
        state_out = 9'b0_0000_0001;
        case (state_q)
            StOff: begin
                lamp_a    = LampOff;
                lamp_b    = LampOff;
                state_out = 9'b0_0000_0001;
            end
            StAllRed:  state_out = 9'b0_0000_0010;
            StARdylw: begin
                lamp_a    = LampRedAmb;
                state_out = 9'b0_0000_0100;
            end
            StAGreen: begin
                lamp_a    = LampGreen;
                state_out = 9'b0_0000_1000;
            end
            StAYellow: begin
                lamp_a    = LampAmber;
                state_out = 9'b0_0001_0000;
            end
            StBRdylw: begin
                lamp_b    = LampRedAmb;
                state_out = 9'b0_0010_0000;
            end
            StBGreen: begin
                lamp_b    = LampGreen;
                state_out = 9'b0_0100_0000;
            end
            StBYellow: begin
                lamp_b    = LampAmber;
                state_out = 9'b0_1000_0000;
            end
            StWalk: begin
                walk      = 1'b1;
                state_out = 9'b1_0000_0000;
            end
            default: begin
                // Unreachable encodings present as OFF.
                lamp_a    = LampOff;
                lamp_b    = LampOff;
                state_out = 9'b0_0000_0001;
            end
        endcase
    end

    assign bus.lamp_a    = lamp_a;
    assign bus.lamp_b    = lamp_b;
    assign bus.walk      = walk;
    assign bus.ped_wait  = pend_p_q;
    assign bus.state_out = state_out;

endmodule
